reset_sequencer: RTL

- Synthesizable, parametrised reset generator. Replaces the fixed simulation-only reset pulse.
- Holds NUM_CHANNELS downstream reset outputs asserted for a programmable number of cycles after the top reset and PLL lock.
- Releases the outputs in staged order (channel 0 first), then reports completion.
- Re-enters reset on loss of lock or a soft reset request. Sits at the top level between the clock/PLL and the CPU, bus and peripheral domains sharing one clock.

---
 rtl/reset_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset generator for a single clock domain.
// Holds NUM_CHANNELS reset outputs after top reset and PLL lock, releases
// them one by one (channel 0 first) and then reports completion.
// Optional watchdog: define RESET_SEQ_WDT_EN to enable the RUN-state
// watchdog that re-enters the reset sequence when it is not kicked.
module reset_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int WDT_CYCLES   = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pll_locked,
    input  logic                    soft_reset_req,
    input  logic                    wdt_kick,
    output logic [NUM_CHANNELS-1:0] rst_out,
    output logic                    done,
    output logic [1:0]              state,
    output logic                    wdt_fired
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam int                    IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W-1:0]      FIRST_IDX = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0]  HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
    localparam logic [CNT_WIDTH-1:0]  WDT_LAST  = CNT_WIDTH'(WDT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [NUM_CHANNELS-1:0] ALL_ONES = '1;

    state_t                  r_state, w_state_nx;
    logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]        r_idx, w_idx_nx;
    logic [NUM_CHANNELS-1:0] r_rst_out, w_rst_nx;
    logic                    r_done, w_done_nx;
    logic                    w_abort;
    logic                    w_go_assert;
    logic                    w_wdt_trip;

    // Loss of lock and soft request share one restart path.
    assign w_abort = !pll_locked || soft_reset_req;

`ifdef RESET_SEQ_WDT_EN
    logic [CNT_WIDTH-1:0] r_wdt_cnt, w_wdt_cnt_nx;
    logic                 r_wdt_fired;
`endif

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_idx_nx    = r_idx;
        w_rst_nx    = r_rst_out;
        w_done_nx   = r_done;
        w_go_assert = 1'b0;
        w_wdt_trip  = 1'b0;
`ifdef RESET_SEQ_WDT_EN
        w_wdt_cnt_nx = '0;
`endif
        unique case (r_state)
            ST_ASSERT: begin
                w_rst_nx  = ALL_ONES;
                w_done_nx = 1'b0;
                w_idx_nx  = '0;
                if (w_abort) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_cnt_nx = '0;
                    w_rst_nx = ALL_ONES << 1;
                    if (NUM_CHANNELS == 1) begin
                        w_state_nx = ST_RUN;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_RELEASE;
                        w_idx_nx   = FIRST_IDX;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (w_abort) begin
                    w_go_assert = 1'b1;
                end else if (r_cnt == GAP_LAST) begin
                    // Lower channels are already zero, so a left shift
                    // clears exactly bit r_idx.
                    w_cnt_nx = '0;
                    w_rst_nx = r_rst_out << 1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nx = ST_RUN;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + FIRST_IDX;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_go_assert = 1'b1;
                end
`ifdef RESET_SEQ_WDT_EN
                else if (wdt_kick) begin
                    w_wdt_cnt_nx = '0;
                end else if (r_wdt_cnt == WDT_LAST) begin
                    w_go_assert = 1'b1;
                    w_wdt_trip  = 1'b1;
                end else begin
                    w_wdt_cnt_nx = r_wdt_cnt + CNT_ONE;
                end
`endif
            end
            default: begin
                w_go_assert = 1'b1;
            end
        endcase
        // Any restart is a full return to ASSERT; no partial release.
        if (w_go_assert) begin
            w_state_nx = ST_ASSERT;
            w_rst_nx   = ALL_ONES;
            w_done_nx  = 1'b0;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
        end
    end

    // Sequencer state register with synchronous top reset.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_state   <= ST_ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= ALL_ONES;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_rst_out <= w_rst_nx;
            r_done    <= w_done_nx;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    // Watchdog counter and sticky fired flag; only top reset clears the flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdt_cnt   <= '0;
            r_wdt_fired <= 1'b0;
        end else begin
            r_wdt_cnt <= w_wdt_cnt_nx;
            if (w_wdt_trip) begin
                r_wdt_fired <= 1'b1;
            end
        end
    end

    assign wdt_fired = r_wdt_fired;
`else
    // Watchdog absent: the kick input and timeout value have no effect.
    logic w_unused_wdt;
    assign w_unused_wdt = ^{wdt_kick, WDT_LAST, w_wdt_trip};
    assign wdt_fired    = 1'b0;
`endif

    assign rst_out = r_rst_out;
    assign done    = r_done;
    assign state   = r_state;

endmodule
